// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Frame bundle carries four digit codes plus per-digit blank/blink masks.
package seg_pkg;

    typedef logic [4:0] digit_t;

    localparam digit_t     DIG_DASH   = 5'd16;
    localparam digit_t     DIG_BLANK  = 5'd31;
    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;
    localparam int         NUM_DIGITS = 4;

    typedef struct packed {
        digit_t [NUM_DIGITS-1:0] codes;
        logic   [NUM_DIGITS-1:0] blank;
        logic   [NUM_DIGITS-1:0] blink;
    } frame_t;

    // Codes above 17 have no glyph and are always dark.
    function automatic logic is_dark(digit_t c, logic bl, logic bk, logic ph);
        return bl | (bk & ph) | (c > 5'd17);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame load handshake plus board-pin outputs of the scan controller.
interface seg_scan_ctrl_if;

    logic        load;
    logic [19:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        busy;
    logic        ack;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    modport master (
        output load, value, blank_mask, blink_mask,
        input  busy, ack, an, seg, frame_tick
    );

    modport slave (
        input  load, value, blank_mask, blink_mask,
        output busy, ack, an, seg, frame_tick
    );

endinterface

// File: rtl/displayer.sv
// Digit code to active-low cathode pattern {dp,g..a}.
// 0-15 hex glyphs, 16 dash, 17 underscore, anything else dark.
module displayer
    import seg_pkg::*;
(
    input  digit_t     i_code,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            5'd0:  o_seg = 8'hC0;
            5'd1:  o_seg = 8'hF9;
            5'd2:  o_seg = 8'hA4;
            5'd3:  o_seg = 8'hB0;
            5'd4:  o_seg = 8'h99;
            5'd5:  o_seg = 8'h92;
            5'd6:  o_seg = 8'h82;
            5'd7:  o_seg = 8'hF8;
            5'd8:  o_seg = 8'h80;
            5'd9:  o_seg = 8'h90;
            5'd10: o_seg = 8'h88;
            5'd11: o_seg = 8'h83;
            5'd12: o_seg = 8'hC6;
            5'd13: o_seg = 8'hA1;
            5'd14: o_seg = 8'h86;
            5'd15: o_seg = 8'h8E;
            5'd16: o_seg = 8'hBF;
            5'd17: o_seg = 8'hF7;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed display scanner with dead time, blink,
// and tear-free frame loading at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYCLES  = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_END  = CW'(DEAD_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;
    frame_t        r_shadow;
    frame_t        r_pending;
    logic          r_pend;

    logic [3:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_ack;
    logic          r_tick;

    frame_t        w_in;
    logic          w_wrap;
    logic          w_bnd;
    logic          w_dead;
    digit_t        w_code;
    logic          w_dark;
    logic [7:0]    w_seg;

    assign w_in   = '{codes: bus.value,
                      blank: bus.blank_mask,
                      blink: bus.blink_mask};
    assign w_wrap = (r_cnt == CNT_MAX);
    assign w_bnd  = w_wrap && (r_idx == 2'd3);
    assign w_dead = (r_cnt < DEAD_END);
    assign w_code = r_shadow.codes[r_idx];
    assign w_dark = is_dark(w_code,
                            r_shadow.blank[r_idx],
                            r_shadow.blink[r_idx],
                            r_phase);

    displayer u_disp (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
            r_shadow  <= '{codes: {NUM_DIGITS{DIG_BLANK}},
                           blank: '0, blink: '0};
            r_pending <= '{codes: {NUM_DIGITS{DIG_BLANK}},
                           blank: '0, blink: '0};
            r_pend    <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap)
                r_idx <= r_idx + 2'd1;
            if (w_bnd) begin
                if (r_bcnt == BLINK_MAX) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
                // A load on the boundary beats an older pending frame.
                if (bus.load) begin
                    r_shadow <= w_in;
                    r_pend   <= 1'b0;
                end else if (r_pend) begin
                    r_shadow <= r_pending;
                    r_pend   <= 1'b0;
                end
            end else if (bus.load) begin
                r_pending <= w_in;
                r_pend    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an   <= AN_OFF;
            r_seg  <= SEG_OFF;
            r_ack  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_ack  <= w_bnd && (bus.load || r_pend);
            r_tick <= w_bnd;
            if (w_dead) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_dark ? SEG_OFF : w_seg;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.ack        = r_ack;
    assign bus.frame_tick = r_tick;
    assign bus.busy       = r_pend;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a cycle-count based
// reference model of the scan, blink and frame-load rules.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int RD = 8;
    localparam int DC = 2;
    localparam int BF = 2;
    localparam int FR = 4 * RD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .DEAD_CYCLES  (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] GLYPH [18] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
        8'hBF, 8'hF7
    };

    int n_chk = 0;
    int n_bad = 0;

    // Model: t counts cycles since reset; slot/digit/frame follow by division.
    int         t;
    int         sh_code [4];
    int         pe_code [4];
    logic [3:0] sh_bl, sh_bk, pe_bl, pe_bk;
    bit         pend;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    bit         e_ack, e_tick;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t    = 0;
        pend = 0;
        for (int i = 0; i < 4; i++) begin
            sh_code[i] = 31;
            pe_code[i] = 31;
        end
        sh_bl  = '0; sh_bk = '0;
        pe_bl  = '0; pe_bk = '0;
        e_an   = 4'hF;
        e_seg  = 8'hFF;
        e_ack  = 0;
        e_tick = 0;
    endtask

    task automatic model_step();
        int  slot, dig, ph, code;
        bit  bnd, dark;
        slot = t % RD;
        dig  = (t / RD) % 4;
        ph   = ((t / FR) / BF) % 2;
        bnd  = (t % FR) == FR - 1;
        if (slot < DC) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end else begin
            code  = sh_code[dig];
            dark  = sh_bl[dig] || (sh_bk[dig] && ph == 1) || code > 17;
            e_an  = 4'hF ^ (4'b0001 << dig);
            e_seg = dark ? 8'hFF : GLYPH[code];
        end
        e_ack  = bnd && (bus.load || pend);
        e_tick = bnd;
        if (bnd) begin
            if (bus.load) begin
                for (int i = 0; i < 4; i++)
                    sh_code[i] = int'(bus.value[5*i +: 5]);
                sh_bl = bus.blank_mask;
                sh_bk = bus.blink_mask;
            end else if (pend) begin
                sh_code = pe_code;
                sh_bl   = pe_bl;
                sh_bk   = pe_bk;
            end
            pend = 0;
        end else if (bus.load) begin
            for (int i = 0; i < 4; i++)
                pe_code[i] = int'(bus.value[5*i +: 5]);
            pe_bl = bus.blank_mask;
            pe_bk = bus.blink_mask;
            pend  = 1;
        end
        t++;
    endtask

    task automatic check_all();
        chk("an",   32'(bus.an),         32'(e_an));
        chk("seg",  32'(bus.seg),        32'(e_seg));
        chk("ack",  32'(bus.ack),        32'(e_ack));
        chk("tick", 32'(bus.frame_tick), 32'(e_tick));
        chk("busy", 32'(bus.busy),       32'(pend));
    endtask

    task automatic cyc(bit l, logic [19:0] v, logic [3:0] bm, logic [3:0] km);
        bus.load       = l;
        bus.value      = v;
        bus.blank_mask = bm;
        bus.blink_mask = km;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 20'h0, 4'h0, 4'h0);
    endtask

    task automatic to_boundary();
        while ((t % FR) != FR - 1)
            idle(1);
    endtask

    function automatic logic [19:0] pack4(int d3, int d2, int d1, int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    initial begin
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_an",  32'(bus.an),  32'h0F);
        chk("rst_seg", 32'(bus.seg), 32'hFF);
        rst = 1'b0;

        idle(35);
        cyc(1'b1, pack4(3, 2, 1, 0), 4'h0, 4'h0);
        idle(70);

        // Queue a frame, then reset mid-slot while a digit is lit.
        cyc(1'b1, pack4(9, 9, 9, 9), 4'h0, 4'h0);
        while ((t % RD) != 5)
            idle(1);
        chk("pre_rst_lit", 32'(bus.an != 4'hF), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an",  32'(bus.an),  32'h0F);
        chk("async_seg", 32'(bus.seg), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(40);

        to_boundary();
        idle(1);
        idle(2);
        cyc(1'b1, pack4(1, 1, 1, 1), 4'h0, 4'h0);
        idle(6);
        cyc(1'b1, pack4(2, 2, 2, 2), 4'h0, 4'h0);
        idle(9);
        cyc(1'b1, pack4(10, 11, 12, 13), 4'h0, 4'h0);
        idle(50);

        to_boundary();
        cyc(1'b1, pack4(7, 6, 5, 4), 4'h0, 4'h0);
        idle(40);

        cyc(1'b1, pack4(20, 5, 16, 31), 4'b0100, 4'h0);
        idle(70);

        cyc(1'b1, pack4(0, 0, 0, 8), 4'h0, 4'b0001);
        idle(FR * 6);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                cyc(1'b1, 20'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    4'($urandom));
            else
                idle(1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
